fsic_wb_cmd_master: RTL and testbench



---
 rtl/fsic_wb_pkg.sv | 27 ++
 rtl/fsic_cmd_fifo.sv | 80 ++++++++
 rtl/fsic_wb_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_fsic_wb_cmd_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsic_wb_pkg.sv
// Shared types for the FSIC Wishbone command master.
// - wb_state_e : bus sequencer states (idle, transaction on bus, post-transaction gap)
// - wb_cmd_t   : one queued command {we, adr, wdata, sel} at the default 32/32 bus widths
package fsic_wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                   we;
    logic [WB_ADDR_W-1:0]   adr;
    logic [WB_DATA_W-1:0]   wdata;
    logic [WB_DATA_W/8-1:0] sel;
  } wb_cmd_t;

  // Width of a flattened command word for arbitrary bus widths.
  function automatic int unsigned wb_cmd_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/fsic_cmd_fifo.sv
// Synchronous command FIFO, pDEPTH entries of pWIDTH bits.
// Ports: clk/rst_n (async active-low), push/wdata in, pop in, rdata = head (valid when !empty),
//        full/empty flags and exact occupancy count.
// A push while full or a pop while empty is ignored; a full FIFO never accepts in the
// same cycle it is popped, so full alone decides acceptance.
module fsic_cmd_fifo #(
  parameter int unsigned pWIDTH = 69,
  parameter int unsigned pDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [pWIDTH-1:0]          wdata,
  input  logic                       pop,
  output logic [pWIDTH-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(pDEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(pDEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(pDEPTH);

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy from the accepted push/pop pair.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - (PTR_W+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(pDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata;
      end
    end
  end

endmodule

// File: rtl/fsic_wb_cmd_master.sv
// Wishbone classic-cycle master fed by a command queue (wb_clk domain).
// Ports: cmd_* push interface (valid/ready), wbs_* Wishbone master signals, rsp_* one-cycle
//        response pulse (read data, echo of we, timeout error), busy, cmd_count (queue occupancy).
// One transaction is on the bus at a time; it ends on wbs_ack or after pTIMEOUT cycles of
// wbs_cyc without ack (pTIMEOUT = 0 disables the timeout). pGAP idle cycles follow each one.
module fsic_wb_cmd_master
  import fsic_wb_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 32,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pCMD_DEPTH  = 4,
  parameter int unsigned pTIMEOUT    = 64,
  parameter int unsigned pGAP        = 0
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [pADDR_WIDTH-1:0]      cmd_adr,
  input  logic [pDATA_WIDTH-1:0]      cmd_wdata,
  input  logic [pDATA_WIDTH/8-1:0]    cmd_sel,
  output logic                        wbs_cyc,
  output logic                        wbs_stb,
  output logic                        wbs_we,
  output logic [pADDR_WIDTH-1:0]      wbs_adr,
  output logic [pDATA_WIDTH-1:0]      wbs_wdata,
  output logic [pDATA_WIDTH/8-1:0]    wbs_sel,
  input  logic                        wbs_ack,
  input  logic [pDATA_WIDTH-1:0]      wbs_rdata,
  output logic                        rsp_valid,
  output logic                        rsp_we,
  output logic [pDATA_WIDTH-1:0]      rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(pCMD_DEPTH):0] cmd_count
);

  localparam int unsigned AW    = pADDR_WIDTH;
  localparam int unsigned DW    = pDATA_WIDTH;
  localparam int unsigned SW    = pDATA_WIDTH / 8;
  localparam int unsigned CW    = wb_cmd_width(AW, DW);
  localparam int unsigned TW    = (pTIMEOUT > 0) ? $clog2(pTIMEOUT + 1) : 1;
  localparam int unsigned GW    = (pGAP > 1) ? $clog2(pGAP) : 1;
  localparam bit          TO_EN = (pTIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((pTIMEOUT > 0) ? pTIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((pGAP > 0) ? pGAP - 1 : 0);
  localparam wb_state_e     POST_ST  = (pGAP > 0) ? ST_GAP : ST_IDLE;

  wb_state_e         state_q, state_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic              pop_s, fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     fifo_rdata_s;
  logic              head_we_s;
  logic [AW-1:0]     head_adr_s;
  logic [DW-1:0]     head_wdata_s;
  logic [SW-1:0]     head_sel_s;

  fsic_cmd_fifo #(
    .pWIDTH (CW),
    .pDEPTH (pCMD_DEPTH)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst),
    .push  (cmd_valid),
    .wdata ({cmd_we, cmd_adr, cmd_wdata, cmd_sel}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (cmd_count)
  );

  assign {head_we_s, head_adr_s, head_wdata_s, head_sel_s} = fifo_rdata_s;

  assign cmd_ready = !fifo_full_s;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty_s;
  assign wbs_cyc   = cyc_q;
  assign wbs_stb   = stb_q;
  assign wbs_we    = we_q;
  assign wbs_adr   = adr_q;
  assign wbs_wdata = wdata_q;
  assign wbs_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Sequencer next state: issue from queue, hold bus until ack/timeout, then optional gap.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_d     = head_we_s;
          adr_d    = head_adr_s;
          wdata_d  = head_wdata_s;
          sel_d    = head_sel_s;
          to_cnt_d = '0;
          state_d  = ST_BUS;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Ack is checked first so an ack on the terminal timeout cycle still succeeds.
        if (wbs_ack || (TO_EN && (to_cnt_q == TO_LAST))) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          wdata_d     = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_err_d   = !wbs_ack;
          rsp_rdata_d = (wbs_ack && !we_q) ? wbs_rdata : '0;
          gap_cnt_d   = '0;
          state_d     = POST_ST;
        end else begin
          to_cnt_d    = to_cnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State, counters, bus and response registers; reset drops the bus with no response.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_fsic_wb_cmd_master.sv
// Scoreboard bench for fsic_wb_cmd_master: commands push expected bus/response records,
// a slave model acks per record, monitors pop and compare.
module tb_fsic_wb_cmd_master;
  import fsic_wb_pkg::*;

  localparam int TO = 16;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0, cmd_wdata = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [31:0] wbs_adr, wbs_wdata;
  logic [3:0]  wbs_sel;
  logic        wbs_ack = 1'b0;
  logic [31:0] wbs_rdata = 32'h0;
  logic        rsp_valid, rsp_we, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [2:0]  cmd_count;

  logic        cmd_valid_g = 1'b0, cmd_ready_g, cmd_we_g = 1'b0;
  logic [31:0] cmd_adr_g = 32'h0, cmd_wdata_g = 32'h0;
  logic [3:0]  cmd_sel_g = 4'h0;
  logic        wbs_cyc_g, wbs_stb_g, wbs_we_g;
  logic [31:0] wbs_adr_g, wbs_wdata_g;
  logic [3:0]  wbs_sel_g;
  logic        wbs_ack_g = 1'b0;
  logic [31:0] wbs_rdata_g = 32'h0;
  logic        rsp_valid_g, rsp_we_g, rsp_err_g, busy_g;
  logic [31:0] rsp_rdata_g;
  logic [2:0]  cmd_count_g;

  always #5 wb_clk = ~wb_clk;

  fsic_wb_cmd_master #(.pADDR_WIDTH(32), .pDATA_WIDTH(32), .pCMD_DEPTH(4), .pTIMEOUT(TO), .pGAP(0)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb),
    .wbs_we(wbs_we), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel), .wbs_ack(wbs_ack),
    .wbs_rdata(wbs_rdata), .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .cmd_count(cmd_count));

  fsic_wb_cmd_master #(.pADDR_WIDTH(32), .pDATA_WIDTH(32), .pCMD_DEPTH(4), .pTIMEOUT(TO), .pGAP(2)) dut_g (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g), .cmd_we(cmd_we_g),
    .cmd_adr(cmd_adr_g), .cmd_wdata(cmd_wdata_g), .cmd_sel(cmd_sel_g), .wbs_cyc(wbs_cyc_g), .wbs_stb(wbs_stb_g),
    .wbs_we(wbs_we_g), .wbs_adr(wbs_adr_g), .wbs_wdata(wbs_wdata_g), .wbs_sel(wbs_sel_g), .wbs_ack(wbs_ack_g),
    .wbs_rdata(wbs_rdata_g), .rsp_valid(rsp_valid_g), .rsp_we(rsp_we_g), .rsp_rdata(rsp_rdata_g),
    .rsp_err(rsp_err_g), .busy(busy_g), .cmd_count(cmd_count_g));

  typedef struct { wb_cmd_t cmd; int delay; logic [31:0] rdata; } txn_t;
  typedef struct { logic we; logic err; logic [31:0] rdata; } rsp_t;

  txn_t plan_q[$];
  txn_t bus_q[$];
  rsp_t rsp_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_gap = 0;
  int   last_gap_g = 0;
  int   n_rsp_g = 0;
  logic stray_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // delay = cycle of wbs_cyc on which the slave acks; 0 = never acks.
  function automatic void push_sb(input wb_cmd_t c, input int delay, input logic [31:0] rd);
    txn_t t;
    rsp_t r;
    bit   err;
    err     = !(delay >= 1 && delay <= TO);
    t.cmd   = c;
    t.delay = delay;
    t.rdata = rd;
    plan_q.push_back(t);
    bus_q.push_back(t);
    r.we    = c.we;
    r.err   = err;
    r.rdata = (!c.we && !err) ? rd : 32'h0;
    rsp_q.push_back(r);
  endfunction

  task automatic offer(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                       input int delay, input logic [31:0] rd, input int max_wait, output bit acc);
    int      w;
    wb_cmd_t c;
    w = 0;
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_wdata = wd; cmd_sel = sel;
    while (!cmd_ready && w < max_wait) begin
      @(negedge wb_clk);
      w++;
    end
    acc = cmd_ready;
    if (acc) begin
      c.we = we; c.adr = adr; c.wdata = wd; c.sel = sel;
      push_sb(c, delay, rd);
    end
    @(posedge wb_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                      input int delay, input logic [31:0] rd);
    bit acc;
    offer(we, adr, wd, sel, delay, rd, 200, acc);
    check_eq("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || rsp_q.size() > 0) && c < budget) begin
      @(negedge wb_clk);
      c++;
    end
    if (busy || rsp_q.size() > 0) check_eq("wait_idle_budget", 64'd0, 64'd1);
    repeat (2) @(negedge wb_clk);
  endtask

  // Slave model: acks on the planned cycle of wbs_cyc; auto-acks the gap instance at once.
  initial begin
    int   scnt;
    txn_t cur;
    scnt = 0;
    cur.delay = 0;
    cur.rdata = 32'h0;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst) begin
        scnt = 0; wbs_ack = 1'b0;
      end else if (wbs_cyc) begin
        if (scnt == 0) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.delay = 0; cur.rdata = 32'h0; end
        end
        scnt++;
        if (cur.delay == scnt) begin wbs_ack = 1'b1; wbs_rdata = cur.rdata; end
        else begin wbs_ack = 1'b0; wbs_rdata = $urandom; end
      end else begin
        scnt = 0; wbs_ack = stray_ack; wbs_rdata = $urandom;
      end
      wbs_ack_g = wbs_cyc_g;
    end
  end

  // Bus monitor: command contents, stability during the cycle, cycle length, low spacing.
  initial begin
    int   bcnt, low_run;
    bit   have;
    txn_t bt;
    bcnt = 0; low_run = 0; have = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst) begin
        bcnt = 0; low_run = 0;
      end else if (wbs_cyc) begin
        if (bcnt == 0) begin
          last_gap = low_run;
          low_run  = 0;
          if (bus_q.size() > 0) begin bt = bus_q.pop_front(); have = 1'b1; end
          else begin have = 1'b0; check_eq("bus_unexpected", 64'd1, 64'd0); end
        end
        bcnt++;
        if (have) begin
          check_eq("bus_stb", 64'(wbs_stb), 64'd1);
          check_eq("bus_we", 64'(wbs_we), 64'(bt.cmd.we));
          check_eq("bus_adr", 64'(wbs_adr), 64'(bt.cmd.adr));
          check_eq("bus_wdata", 64'(wbs_wdata), 64'(bt.cmd.wdata));
          check_eq("bus_sel", 64'(wbs_sel), 64'(bt.cmd.sel));
        end
      end else begin
        if (bcnt > 0 && have)
          check_eq("cyc_len", 64'(bcnt), 64'((bt.delay >= 1 && bt.delay <= TO) ? bt.delay : TO));
        bcnt = 0;
        low_run++;
      end
    end
  end

  // Response monitor: pops the expected response on every rsp_valid pulse.
  initial begin
    rsp_t r;
    forever begin
      @(negedge wb_clk);
      if (wb_rst && rsp_valid) begin
        if (rsp_q.size() == 0) check_eq("rsp_unexpected", 64'd1, 64'd0);
        else begin
          r = rsp_q.pop_front();
          check_eq("rsp_we", 64'(rsp_we), 64'(r.we));
          check_eq("rsp_err", 64'(rsp_err), 64'(r.err));
          check_eq("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        end
      end
    end
  end

  // Gap-instance monitor: low cycles between transactions and response count.
  initial begin
    int  low_g;
    logic prev_g;
    low_g = 0; prev_g = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (wb_rst) begin
        if (wbs_cyc_g && !prev_g) begin last_gap_g = low_g; low_g = 0; end
        else if (!wbs_cyc_g) low_g++;
        if (rsp_valid_g) begin
          n_rsp_g++;
          check_eq("g_rsp_err", 64'(rsp_err_g), 64'd0);
        end
        prev_g = wbs_cyc_g;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    // Reset values.
    repeat (3) @(negedge wb_clk);
    check_eq("rst_cyc", 64'(wbs_cyc), 64'd0);
    check_eq("rst_stb", 64'(wbs_stb), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_count", 64'(cmd_count), 64'd0);
    check_eq("rst_ready", 64'(cmd_ready), 64'd1);
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);

    // Single write, ack on 3rd cycle; bus rises one edge after acceptance.
    send(1'b1, 32'h3000_3000, 32'h0000_0001, 4'b0001, 3, 32'h0);
    check_eq("lat_accept_edge", 64'(wbs_cyc), 64'd0);
    @(posedge wb_clk); #1;
    check_eq("lat_next_edge", 64'(wbs_cyc), 64'd1);
    wait_idle(100);

    // Read, ack on 1st cycle.
    send(1'b0, 32'h3000_3004, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
    wait_idle(100);

    // Queue full: first transaction held on the bus, six back-to-back offers.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      offer(i[0], 32'h3000_3100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF,
            (i == 0) ? 12 : 2, 32'h5A00_0000 + 32'(i), 0, acc);
      if (acc) n_acc++;
    end
    check_eq("qfull_accepted", 64'(n_acc), 64'd5);
    check_eq("qfull_count", 64'(cmd_count), 64'd4);
    check_eq("qfull_ready", 64'(cmd_ready), 64'd0);
    wait_idle(400);

    // Timeout, then the queued read issues; ack on the terminal cycle wins; late ack times out.
    send(1'b1, 32'h3000_3200, 32'h1111_2222, 4'h3, 0, 32'h0);
    send(1'b0, 32'h3000_3204, 32'h0, 4'hF, 2, 32'h1234_5678);
    wait_idle(200);
    send(1'b0, 32'h3000_3208, 32'h0, 4'hF, TO, 32'hCAFE_F00D);
    wait_idle(200);
    send(1'b0, 32'h3000_320C, 32'h0, 4'hF, TO + 1, 32'hBAD0_BAD0);
    wait_idle(200);

    // Spacing with pGAP = 0: one low cycle between back-to-back transactions.
    send(1'b1, 32'h3000_3300, 32'h0000_00AA, 4'hF, 1, 32'h0);
    send(1'b1, 32'h3000_3304, 32'h0000_00BB, 4'hF, 1, 32'h0);
    wait_idle(100);
    check_eq("gap_p0", 64'(last_gap), 64'd1);

    // Spacing with pGAP = 2: three low cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk);
      cmd_valid_g = 1'b1; cmd_we_g = 1'b1; cmd_adr_g = 32'h3000_3400 + 32'(i * 4);
      cmd_wdata_g = 32'(i); cmd_sel_g = 4'hF;
    end
    @(negedge wb_clk);
    cmd_valid_g = 1'b0;
    repeat (20) @(negedge wb_clk);
    check_eq("gap_p2", 64'(last_gap_g), 64'd3);
    check_eq("gap_p2_rsp", 64'(n_rsp_g), 64'd2);

    // Stray ack while idle is ignored (an unexpected response would be flagged).
    @(negedge wb_clk);
    stray_ack = 1'b1;
    repeat (5) @(negedge wb_clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge wb_clk);
    check_eq("stray_busy", 64'(busy), 64'd0);

    // Reset during BUS with two commands queued.
    send(1'b1, 32'h3000_3500, 32'h0, 4'hF, 0, 32'h0);
    send(1'b1, 32'h3000_3504, 32'h0, 4'hF, 0, 32'h0);
    send(1'b1, 32'h3000_3508, 32'h0, 4'hF, 0, 32'h0);
    check_eq("mid_count", 64'(cmd_count), 64'd2);
    check_eq("mid_cyc", 64'(wbs_cyc), 64'd1);
    #2;
    wb_rst = 1'b0;
    #1;
    check_eq("arst_cyc", 64'(wbs_cyc), 64'd0);
    check_eq("arst_stb", 64'(wbs_stb), 64'd0);
    check_eq("arst_count", 64'(cmd_count), 64'd0);
    check_eq("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    plan_q.delete();
    bus_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (20) @(negedge wb_clk);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_cyc", 64'(wbs_cyc), 64'd0);

    // Block still works after reset.
    send(1'b0, 32'h3000_3600, 32'h0, 4'hF, 2, 32'h0BAD_CAFE);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
